dga_panel_fifo: RTL and testbench

Parametrised synchronous panel FIFO for the decode gate array. It sits between the internal data bus input (IDB) and the panel address output (XA).
- Written on the panel-load strobe; read on the read-memory strobe.
- Compared with the fixed 8-bit, 13-deep panel FIFO, it adds configurable width and depth, a fill-level count, almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous clear.
- All state is clocked on one clock.

---
 rtl/dga_pkg.sv | 15 +
 rtl/dga_panel_fifo_if.sv | 39 +++
 rtl/dga_fifo_ptr.sv | 23 ++
 rtl/dga_panel_fifo.sv | 73 +++++++
 tb/tb_dga_panel_fifo.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/dga_pkg.sv
// dga_pkg: shared constants and width helpers for the decode gate array panel FIFO
package dga_pkg;
  localparam int DGA_PFIFO_WIDTH_DEF = 8;
  localparam int DGA_PFIFO_DEPTH_DEF = 13;
  localparam int DGA_PFIFO_LVL_MAX_W = 7;
  // Wide enough for any level or pointer of a FIFO up to 64 entries.
  typedef logic [DGA_PFIFO_LVL_MAX_W-1:0] dga_lvl_t;
  // Bits needed to hold every value 0..n (n >= 1).
  function automatic int clog2_depth(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction
endpackage

// File: rtl/dga_panel_fifo_if.sv
// dga_panel_fifo_if: IDB-to-XA panel FIFO bus
//   master drives clear_n, wr_en, rd_en, data_in
//   slave drives data_out, full_n, empty_n, level, afull, aempty, ovf, udf
//   (and hwm when DGA_PANEL_FIFO_HWM_EN is defined)
interface dga_panel_fifo_if #(
  parameter int WIDTH = dga_pkg::DGA_PFIFO_WIDTH_DEF,
  parameter int DEPTH = dga_pkg::DGA_PFIFO_DEPTH_DEF
);
  localparam int LW = dga_pkg::clog2_depth(DEPTH);
  logic             clear_n;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full_n;
  logic             empty_n;
  logic [LW-1:0]    level;
  logic             afull;
  logic             aempty;
  logic             ovf;
  logic             udf;
`ifdef DGA_PANEL_FIFO_HWM_EN
  logic [LW-1:0]    hwm;
`endif
  modport master (
    output clear_n, wr_en, rd_en, data_in,
`ifdef DGA_PANEL_FIFO_HWM_EN
    input  hwm,
`endif
    input  data_out, full_n, empty_n, level, afull, aempty, ovf, udf
  );
  modport slave (
    input  clear_n, wr_en, rd_en, data_in,
`ifdef DGA_PANEL_FIFO_HWM_EN
    output hwm,
`endif
    output data_out, full_n, empty_n, level, afull, aempty, ovf, udf
  );
endinterface

// File: rtl/dga_fifo_ptr.sv
// dga_fifo_ptr: modulo-DEPTH pointer register
//   sysclk, sys_rst_n (async, active-low), clear_n (sync, active-low), inc -> ptr
module dga_fifo_ptr
  import dga_pkg::*;
#(
  parameter int DEPTH = DGA_PFIFO_DEPTH_DEF,
  parameter int PW    = clog2_depth(DEPTH - 1)
) (
  input  logic          sysclk,
  input  logic          sys_rst_n,
  input  logic          clear_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [PW-1:0] ptr_q, ptr_d;
  // Explicit wrap compare so non-power-of-two depths count correctly.
  always_comb ptr_d = !clear_n ? '0 : !inc ? ptr_q : (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  always_ff @(posedge sysclk or negedge sys_rst_n)
    if (!sys_rst_n) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/dga_panel_fifo.sv
// dga_panel_fifo: parametrised first-word-fall-through panel FIFO between IDB and XA
//   sysclk     system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        dga_panel_fifo_if.slave: clear_n/wr_en/rd_en/data_in in;
//              data_out/full_n/empty_n/level/afull/aempty/ovf/udf out
//   DGA_PANEL_FIFO_HWM_EN adds bus.hwm, the high-water mark since reset/clear.
module dga_panel_fifo
  import dga_pkg::*;
#(
  parameter int WIDTH     = DGA_PFIFO_WIDTH_DEF,
  parameter int DEPTH     = DGA_PFIFO_DEPTH_DEF,
  parameter int AFULL_TH  = 11,
  parameter int AEMPTY_TH = 2
) (
  input logic             sysclk,
  input logic             sys_rst_n,
  dga_panel_fifo_if.slave bus
);
  localparam int LW = clog2_depth(DEPTH);
  localparam int PW = clog2_depth(DEPTH - 1);
  localparam logic [LW-1:0] LDEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] LAF    = LW'(AFULL_TH);
  localparam logic [LW-1:0] LAE    = LW'(AEMPTY_TH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, wr_ok, rd_ok;
  assign full  = level_q == LDEPTH;
  assign empty = level_q == '0;
  // A full FIFO still accepts a write when the same cycle pops the head.
  assign wr_ok = bus.clear_n && bus.wr_en && (!full || bus.rd_en);
  assign rd_ok = bus.clear_n && bus.rd_en && !empty;
  always_comb begin
    level_d = !bus.clear_n ? '0 : level_q + LW'(wr_ok) - LW'(rd_ok);
    ovf_d   = bus.clear_n && (ovf_q || (bus.wr_en && full && !bus.rd_en));
    udf_d   = bus.clear_n && (udf_q || (bus.rd_en && empty));
  end
  always_ff @(posedge sysclk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  always_ff @(posedge sysclk)
    if (wr_ok) mem[wr_ptr] <= bus.data_in;
  dga_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .clear_n(bus.clear_n), .inc(wr_ok), .ptr(wr_ptr)
  );
  dga_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .clear_n(bus.clear_n), .inc(rd_ok), .ptr(rd_ptr)
  );
  assign bus.data_out = empty ? '0 : mem[rd_ptr];
  assign bus.full_n   = !full;
  assign bus.empty_n  = !empty;
  assign bus.level    = level_q;
  assign bus.afull    = level_q >= LAF;
  assign bus.aempty   = level_q <= LAE;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
`ifdef DGA_PANEL_FIFO_HWM_EN
  logic [LW-1:0] hwm_q, hwm_d;
  always_comb hwm_d = !bus.clear_n ? '0 : (level_d > hwm_q) ? level_d : hwm_q;
  always_ff @(posedge sysclk or negedge sys_rst_n)
    if (!sys_rst_n) hwm_q <= '0;
    else            hwm_q <= hwm_d;
  assign bus.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_dga_panel_fifo.sv
// tb_dga_panel_fifo: directed vectors for the default 8x13 FIFO plus a 16x4 instance
module tb_dga_panel_fifo;
  logic sysclk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 sysclk = ~sysclk;

  dga_panel_fifo_if #(.WIDTH(8),  .DEPTH(13)) ifa ();
  dga_panel_fifo_if #(.WIDTH(16), .DEPTH(4))  ifb ();
  dga_panel_fifo #(.WIDTH(8), .DEPTH(13), .AFULL_TH(11), .AEMPTY_TH(2)) ua (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .bus(ifa.slave)
  );
  dga_panel_fifo #(.WIDTH(16), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) ub (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .bus(ifb.slave)
  );

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    logic [3:0] lvl;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(int wr, int rd, int clr, int din, int lvl, int dout, int ovf, int udf);
    vec_t v;
    v.wr = 1'(wr); v.rd = 1'(rd); v.clr = 1'(clr);
    v.din = 8'(din); v.lvl = 4'(lvl); v.dout = 8'(dout);
    v.ovf = 1'(ovf); v.udf = 1'(udf);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int lvl, input int dout, input int ovf, input int udf);
    chk({tag, ".level"},   32'(ifa.level),    32'(lvl));
    chk({tag, ".dout"},    32'(ifa.data_out), 32'(dout));
    chk({tag, ".full_n"},  32'(ifa.full_n),   32'(lvl != 13));
    chk({tag, ".empty_n"}, 32'(ifa.empty_n),  32'(lvl != 0));
    chk({tag, ".afull"},   32'(ifa.afull),    32'(lvl >= 11));
    chk({tag, ".aempty"},  32'(ifa.aempty),   32'(lvl <= 2));
    chk({tag, ".ovf"},     32'(ifa.ovf),      32'(ovf));
    chk({tag, ".udf"},     32'(ifa.udf),      32'(udf));
  endtask

  task automatic step_a(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
    ifa.wr_en = wr; ifa.rd_en = rd; ifa.clear_n = !clr; ifa.data_in = din;
    @(posedge sysclk); #1;
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.clear_n = 1'b1;
  endtask

  task automatic step_b(input logic wr, input logic rd, input logic [15:0] din);
    ifb.wr_en = wr; ifb.rd_en = rd; ifb.data_in = din;
    @(posedge sysclk); #1;
    ifb.wr_en = 1'b0; ifb.rd_en = 1'b0;
  endtask

  task automatic chk_b(input string tag, input int lvl, input int dout, input int full_n,
                       input int afull, input int aempty, input int ovf);
    chk({tag, ".level"},  32'(ifb.level),    32'(lvl));
    chk({tag, ".dout"},   32'(ifb.data_out), 32'(dout));
    chk({tag, ".full_n"}, 32'(ifb.full_n),   32'(full_n));
    chk({tag, ".afull"},  32'(ifb.afull),    32'(afull));
    chk({tag, ".aempty"}, 32'(ifb.aempty),   32'(aempty));
    chk({tag, ".ovf"},    32'(ifb.ovf),      32'(ovf));
  endtask

  initial begin
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.clear_n = 1'b1; ifa.data_in = '0;
    ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.clear_n = 1'b1; ifb.data_in = '0;

    for (int i = 0; i < 13; i++) vecs.push_back(mk(1, 0, 0, i + 1, i + 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 'hEE, 13, 1, 1, 0));
    for (int k = 1; k <= 13; k++) vecs.push_back(mk(0, 1, 0, 0, 13 - k, k < 13 ? k + 1 : 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 0, 0, 'h10 + i, i + 1, 'h10, 0, 0));
    for (int k = 1; k <= 10; k++) vecs.push_back(mk(0, 1, 0, 0, 10 - k, k < 10 ? 'h10 + k : 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, 'hA0 + i, i + 1, 'hA0, 0, 0));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 1, 0, 0, 8 - k, k < 8 ? 'hA0 + k : 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 'h30 + i, i + 1, 'h30, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h35, 5, 'h31, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, 'h36 + i, 6 + i, 'h31, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h3E, 13, 'h32, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h55, 1, 'h55, 0, 1));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 0, 0, 'h56 + i, 2 + i, 'h55, 0, 1));
    vecs.push_back(mk(1, 0, 1, 'hEE, 0, 0, 0, 0));

    repeat (2) @(posedge sysclk);
    #1;
    chk_a("reset", 0, 0, 0, 0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk_a($sformatf("v%0d", i), vecs[i].lvl, vecs[i].dout, vecs[i].ovf, vecs[i].udf);
    end

    // Asynchronous reset mid-cycle with udf set and data stored.
    step_a(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step_a(1, 0, 0, 8'h70 + 8'(i));
    chk_a("pre_arst", 3, 'h70, 0, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_a("arst", 0, 0, 0, 0);
`ifdef DGA_PANEL_FIFO_HWM_EN
    chk("arst.hwm", 32'(ifa.hwm), 32'd0);
`endif
    @(posedge sysclk); #1;
    sys_rst_n = 1'b1;

    // Generalised 16x4 instance.
    chk_b("b_reset", 0, 0, 1, 0, 1, 0);
    step_b(1, 0, 16'hBEEF); chk_b("b_w1", 1, 'hBEEF, 1, 0, 1, 0);
    step_b(1, 0, 16'h1111); chk_b("b_w2", 2, 'hBEEF, 1, 0, 0, 0);
    step_b(1, 0, 16'h2222); chk_b("b_w3", 3, 'hBEEF, 1, 1, 0, 0);
    step_b(0, 1, 16'h0);    chk_b("b_r1", 2, 'h1111, 1, 0, 0, 0);
    step_b(0, 1, 16'h0);    chk_b("b_r2", 1, 'h2222, 1, 0, 1, 0);
`ifdef DGA_PANEL_FIFO_HWM_EN
    chk("b_hwm", 32'(ifb.hwm), 32'd3);
`endif
    step_b(1, 0, 16'h3333);
    step_b(1, 0, 16'h4444);
    step_b(1, 0, 16'h5555); chk_b("b_full", 4, 'h2222, 0, 1, 0, 0);
    step_b(1, 0, 16'h6666); chk_b("b_ovf", 4, 'h2222, 0, 1, 0, 1);
    step_b(0, 1, 16'h0);    chk_b("b_r3", 3, 'h3333, 1, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
